morse_keyer_ctrl: RTL and testbench

- Sequences one Morse character or word space onto a single key output, using a unit-time prescaler.
- Sits between the memory-mapped Morse peripheral register interface (requester) and the LED/GPIO key pin.
- Accepts a symbol pattern with a ready/req handshake. Generates the mark, symbol-gap and character-gap timing. Reports completion with a one-cycle done pulse.

---
 rtl/morse_keyer_ctrl_pkg.sv | 28 ++
 rtl/morse_counter.sv | 34 +++
 rtl/morse_keyer_ctrl.sv | 148 ++++++++++++++
 tb/tb_morse_keyer_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/morse_keyer_ctrl_pkg.sv
// Shared definitions for the Morse keyer: FSM state encoding, element lengths
// in Morse time units and the unit-counter width.
package morse_keyer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MARK = 2'd1,
        ST_GAP  = 2'd2,
        ST_TAIL = 2'd3
    } keyer_state_e;

    localparam int DOT_UNITS      = 1;
    localparam int DASH_UNITS     = 3;
    localparam int SYM_GAP_UNITS  = 1;
    localparam int CHAR_GAP_UNITS = 3;
    localparam int WORD_GAP_UNITS = 7;

    localparam int UNIT_CNT_W = 3;

    typedef logic [UNIT_CNT_W-1:0] unit_cnt_t;

    // The unit counter ends an element when it reads zero at a tick, so it
    // is preloaded with one less than the element length.
    function automatic unit_cnt_t units_load(input int units);
        return unit_cnt_t'(units - 1);
    endfunction

endpackage

// File: rtl/morse_counter.sv
// Load/enable down-counter with rollover strobe; used as the Morse unit-time
// prescaler. Counts START_AT-1 down to 0, then reloads by itself.
module morse_counter #(
    parameter int WIDTH    = 20,
    parameter int START_AT = 600000
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic load_i,
    input  logic enable_i,
    output logic rollover_o
);

    localparam logic [WIDTH-1:0] RELOAD = WIDTH'(START_AT - 1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count <= '0;
        end else if (load_i) begin
            count <= RELOAD;
        end else if (enable_i) begin
            if (count == '0) begin
                count <= RELOAD;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign rollover_o = enable_i && (count == '0);

endmodule

// File: rtl/morse_keyer_ctrl.sv
// Morse keyer controller: sequences one character (or a word space) onto the
// key output using a unit-time prescaler, then pulses done_o.
module morse_keyer_ctrl
    import morse_keyer_ctrl_pkg::*;
#(
    parameter int UNIT_CYCLES = 600000,
    parameter int PRE_W       = 20,
    parameter int MAX_SYMS    = 6
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                req_i,
    input  logic [MAX_SYMS-1:0] code_i,
    input  logic [2:0]          len_i,
    input  logic                abort_i,
    output logic                ready_o,
    output logic                busy_o,
    output logic                key_o,
    output logic                done_o
);

    localparam logic [2:0] MAX_LEN = 3'(MAX_SYMS);

    keyer_state_e        state, state_next;
    unit_cnt_t           unit_cnt, unit_next;
    logic [2:0]          sym_idx, idx_next;
    logic [2:0]          len_q, len_next;
    logic [MAX_SYMS-1:0] code_q, code_next;
    logic                key_next, done_next;
    logic                entry;
    logic                tick;
    logic                elem_end;
    logic [2:0]          len_clamped;
    logic [2:0]          idx_inc;

    assign len_clamped = (len_i > MAX_LEN) ? MAX_LEN : len_i;
    assign idx_inc     = sym_idx + 3'd1;
    assign elem_end    = tick && (unit_cnt == '0);

    assign ready_o = (state == ST_IDLE);
    assign busy_o  = ~ready_o;

    morse_counter #(
        .WIDTH    (PRE_W),
        .START_AT (UNIT_CYCLES)
    ) u_prescaler (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .load_i     (entry),
        .enable_i   (busy_o),
        .rollover_o (tick)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= ST_IDLE;
            unit_cnt <= '0;
            sym_idx  <= '0;
            len_q    <= '0;
            code_q   <= '0;
            key_o    <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state    <= state_next;
            unit_cnt <= unit_next;
            sym_idx  <= idx_next;
            len_q    <= len_next;
            code_q   <= code_next;
            key_o    <= key_next;
            done_o   <= done_next;
        end
    end

    // Every transition raises 'entry' so the prescaler restarts a full unit
    // on the same edge the new element begins.
    always_comb begin
        state_next = state;
        unit_next  = unit_cnt;
        idx_next   = sym_idx;
        len_next   = len_q;
        code_next  = code_q;
        done_next  = 1'b0;
        entry      = 1'b0;

        if (tick && (unit_cnt != '0)) begin
            unit_next = unit_cnt - 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (req_i && !abort_i) begin
                    code_next = code_i;
                    len_next  = len_clamped;
                    idx_next  = '0;
                    entry     = 1'b1;
                    if (len_clamped != 3'd0) begin
                        state_next = ST_MARK;
                        unit_next  = code_i[0] ? units_load(DASH_UNITS)
                                               : units_load(DOT_UNITS);
                    end else begin
                        state_next = ST_TAIL;
                        unit_next  = units_load(WORD_GAP_UNITS);
                    end
                end
            end
            ST_MARK: begin
                if (elem_end) begin
                    entry = 1'b1;
                    if (idx_inc == len_q) begin
                        state_next = ST_TAIL;
                        unit_next  = units_load(CHAR_GAP_UNITS);
                    end else begin
                        state_next = ST_GAP;
                        unit_next  = units_load(SYM_GAP_UNITS);
                    end
                end
            end
            ST_GAP: begin
                if (elem_end) begin
                    entry      = 1'b1;
                    idx_next   = idx_inc;
                    state_next = ST_MARK;
                    unit_next  = code_q[idx_inc] ? units_load(DASH_UNITS)
                                                 : units_load(DOT_UNITS);
                end
            end
            ST_TAIL: begin
                if (elem_end) begin
                    entry      = 1'b1;
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (abort_i && (state != ST_IDLE)) begin
            state_next = ST_IDLE;
            done_next  = 1'b0;
            entry      = 1'b1;
        end

        key_next = (state_next == ST_MARK);
    end

endmodule

// File: tb/tb_morse_keyer_ctrl.sv
// Self-checking bench for morse_keyer_ctrl: expected key waveforms are built
// from Morse timing rules (dot/dash/gap lengths), not from the FSM.
module tb_morse_keyer_ctrl;

    localparam int U = 4;

    logic       clk_i;
    logic       rstn_i;
    logic       req_i;
    logic [5:0] code_i;
    logic [2:0] len_i;
    logic       abort_i;
    logic       ready_o;
    logic       busy_o;
    logic       key_o;
    logic       done_o;

    int checks = 0;
    int errors = 0;
    bit exp_wave[$];

    morse_keyer_ctrl #(
        .UNIT_CYCLES (U),
        .PRE_W       (3),
        .MAX_SYMS    (6)
    ) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .req_i   (req_i),
        .code_i  (code_i),
        .len_i   (len_i),
        .abort_i (abort_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .key_o   (key_o),
        .done_o  (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic applyStimulus(input logic req, input logic [5:0] code,
                                 input logic [2:0] len, input logic abort);
        req_i   = req;
        code_i  = code;
        len_i   = len;
        abort_i = abort;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Key waveform from Morse rules: dot 1 unit, dash 3, gaps of 1 between
    // symbols, 3 after a character, 7 for a word space.
    task automatic buildWave(input logic [5:0] code, input logic [2:0] len);
        int n;
        n = (len > 3'd6) ? 6 : int'(len);
        exp_wave.delete();
        if (n == 0) begin
            repeat (7 * U) exp_wave.push_back(1'b0);
        end else begin
            for (int s = 0; s < n; s++) begin
                repeat ((code[s] ? 3 : 1) * U) exp_wave.push_back(1'b1);
                if (s != n - 1) repeat (U) exp_wave.push_back(1'b0);
            end
            repeat (3 * U) exp_wave.push_back(1'b0);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge of the done cycle
    // (holdReq) or one cycle later with req dropped.
    task automatic runChar(input logic [5:0] code, input logic [2:0] len,
                           input bit noisy, input bit hold_req);
        buildWave(code, len);
        applyStimulus(1'b1, code, len, 1'b0);
        for (int k = 1; k <= exp_wave.size(); k++) begin
            @(negedge clk_i);
            checkOutput("key", key_o, exp_wave[k-1]);
            checkOutput("busy", busy_o, 1'b1);
            checkOutput("ready_busy", ready_o, 1'b0);
            checkOutput("done_early", done_o, 1'b0);
            if (noisy)
                applyStimulus(1'($urandom_range(0, 1)), 6'($urandom), 3'($urandom), 1'b0);
            else
                applyStimulus(hold_req, code, len, 1'b0);
        end
        @(negedge clk_i);
        checkOutput("done_pulse", done_o, 1'b1);
        checkOutput("ready_at_done", ready_o, 1'b1);
        checkOutput("key_at_done", key_o, 1'b0);
        if (!hold_req) begin
            applyStimulus(1'b0, 6'd0, 3'd0, 1'b0);
            @(negedge clk_i);
            checkOutput("done_single", done_o, 1'b0);
            checkOutput("ready_after", ready_o, 1'b1);
            checkOutput("busy_after", busy_o, 1'b0);
        end
    endtask

    initial begin
        rstn_i = 1'b0;
        applyStimulus(1'b0, 6'd0, 3'd0, 1'b0);
        repeat (3) @(negedge clk_i);
        checkOutput("rst_ready", ready_o, 1'b1);
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_key", key_o, 1'b0);
        checkOutput("rst_done", done_o, 1'b0);
        rstn_i = 1'b1;

        repeat (20) begin
            @(negedge clk_i);
            checkOutput("idle_ready", ready_o, 1'b1);
            checkOutput("idle_key", key_o, 1'b0);
            checkOutput("idle_done", done_o, 1'b0);
        end

        $display("[TB] letter A");
        runChar(6'b000010, 3'd2, 1'b0, 1'b0);

        $display("[TB] word space");
        runChar(6'b101010, 3'd0, 1'b0, 1'b0);

        $display("[TB] len 7 clamped to 6 dashes");
        runChar(6'b111111, 3'd7, 1'b0, 1'b0);

        $display("[TB] abort during A");
        buildWave(6'b000010, 3'd2);
        applyStimulus(1'b1, 6'b000010, 3'd2, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_i);
            checkOutput("abort_pre_key", key_o, exp_wave[k-1]);
            applyStimulus(1'b0, 6'b000010, 3'd2, (k == 10) ? 1'b1 : 1'b0);
        end
        @(negedge clk_i);
        checkOutput("abort_key", key_o, 1'b0);
        checkOutput("abort_ready", ready_o, 1'b1);
        checkOutput("abort_done", done_o, 1'b0);
        applyStimulus(1'b0, 6'd0, 3'd0, 1'b0);
        repeat (40) begin
            @(negedge clk_i);
            checkOutput("post_abort_done", done_o, 1'b0);
            checkOutput("post_abort_key", key_o, 1'b0);
        end

        $display("[TB] req with abort in idle");
        applyStimulus(1'b1, 6'b000001, 3'd1, 1'b1);
        @(negedge clk_i);
        checkOutput("blocked_ready", ready_o, 1'b1);
        checkOutput("blocked_key", key_o, 1'b0);
        applyStimulus(1'b0, 6'd0, 3'd0, 1'b0);
        repeat (15) begin
            @(negedge clk_i);
            checkOutput("blocked_busy", busy_o, 1'b0);
            checkOutput("blocked_done", done_o, 1'b0);
        end

        $display("[TB] back-to-back E E");
        runChar(6'b000000, 3'd1, 1'b0, 1'b1);
        runChar(6'b000000, 3'd1, 1'b0, 1'b0);

        $display("[TB] async reset while busy");
        applyStimulus(1'b1, 6'b000111, 3'd3, 1'b0);
        repeat (5) @(negedge clk_i);
        applyStimulus(1'b0, 6'd0, 3'd0, 1'b0);
        checkOutput("pre_rst_key", key_o, 1'b1);
        #2 rstn_i = 1'b0;
        #1;
        checkOutput("async_rst_key", key_o, 1'b0);
        checkOutput("async_rst_ready", ready_o, 1'b1);
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (30) begin
            @(negedge clk_i);
            checkOutput("post_rst_key", key_o, 1'b0);
            checkOutput("post_rst_done", done_o, 1'b0);
        end

        $display("[TB] random characters with busy-time noise");
        repeat (12) begin
            runChar(6'($urandom), 3'($urandom_range(0, 7)), 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
